// File: rtl/elastic_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with per-stage ready,
// bubble collapse under backpressure, synchronous flush and occupancy count.
module elastic_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             room;
    logic             accept;

    // Walk from the output back to stage 0: "room" means the stage being
    // visited may hand its entry forward this cycle.
    always_comb begin
        adv  = '0;
        room = out_ready & ~flush & ~reset;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            adv[DEPTH-1-i] = v[DEPTH-1-i] & room;
            room           = ~v[DEPTH-1-i] | room;
        end
        in_ready = room & ~flush & ~reset;
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = v[DEPTH-1] & ~flush & ~reset;
    assign out_data  = out_valid ? d[DEPTH-1] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (accept) begin
                v[0] <= 1'b1;
                d[0] <= in_data;
            end else if (adv[0]) begin
                v[0] <= 1'b0;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i-1]) begin
                    v[i] <= 1'b1;
                    d[i] <= d[i-1];
                end else if (adv[i]) begin
                    v[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe (WIDTH=8, DEPTH=4): directed scenarios
// plus a randomized run against a queue-of-entries reference model.
module tb_elastic_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        int         pos;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        tick(); tick();
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_held: got %b expected 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid_held: got %b expected 0", out_valid); else passed++;
        total++; if (occupancy !== 3'd0) $display("FAIL reset_occ_held: got %0d expected 0", occupancy); else passed++;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); else passed++;
        total++; if ({out_valid, out_data} !== 9'h000) $display("FAIL reset_out_after: got %b/%h expected 0/00", out_valid, out_data); else passed++;
        total++; if (occupancy !== 3'd0) $display("FAIL reset_occ_after: got %0d expected 0", occupancy); else passed++;
    endtask

    task automatic test_stream();
        logic [7:0] got[$];
        int         when[$];
        int         t0;
        do_reset();
        out_ready = 1'b1;
        t0 = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 4);
            in_data  = 8'(32'h11 + i);
            tick();
            if (i == 0) t0 = cyc;
            if (out_valid) begin
                got.push_back(out_data);
                when.push_back(cyc);
            end
        end
        in_valid = 1'b0;
        total++; if (got.size() !== 4) $display("FAIL stream_count: got %0d expected 4", got.size()); else passed++;
        for (int j = 0; j < 4; j++) begin
            total++; if (got[j] !== 8'(32'h11 + j)) $display("FAIL stream_data[%0d]: got %h expected %h", j, got[j], 8'(32'h11 + j)); else passed++;
            total++; if (when[j] !== t0 + 3 + j) $display("FAIL stream_time[%0d]: got %0d expected %0d", j, when[j] - t0, 3 + j); else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(32'h21 + i);
            #1;
            total++; if (in_ready !== (i < 4)) $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 4)); else passed++;
            if (i < 4) tick();
        end
        total++; if (occupancy !== 3'd4) $display("FAIL bp_occ_full: got %0d expected 4", occupancy); else passed++;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_release: got %b expected 1", in_ready); else passed++;
        for (int j = 0; j < 5; j++) begin
            total++;
            if ({out_valid, out_data} !== {1'b1, 8'(32'h21 + j)})
                $display("FAIL bp_out[%0d]: got %b/%h expected 1/%h", j, out_valid, out_data, 8'(32'h21 + j));
            else passed++;
            tick();
            in_valid = 1'b0;
        end
        total++; if (occupancy !== 3'd0) $display("FAIL bp_occ_drained: got %0d expected 0", occupancy); else passed++;
    endtask

    task automatic test_bubble();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        in_valid = 1'b1; in_data = 8'hA2;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        total++; if (occupancy !== 3'd2) $display("FAIL bubble_occ: got %0d expected 2", occupancy); else passed++;
        total++; if (dut.v !== 4'b1100) $display("FAIL bubble_valid_bits: got %b expected 1100", dut.v); else passed++;
        total++; if (dut.d[2] !== 8'hA2) $display("FAIL bubble_d2: got %h expected a2", dut.d[2]); else passed++;
        total++; if ({out_valid, out_data} !== 9'h1A1) $display("FAIL bubble_head: got %b/%h expected 1/a1", out_valid, out_data); else passed++;
        out_ready = 1'b1;
        tick();
        total++; if ({out_valid, out_data} !== 9'h1A2) $display("FAIL bubble_second: got %b/%h expected 1/a2", out_valid, out_data); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL bubble_empty: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_full_throughput();
        logic [7:0] exp_q[$];
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(32'h30 + i);
            exp_q.push_back(in_data);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(32'h40 + i);
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL full_in_ready[%0d]: got %b expected 1", i, in_ready); else passed++;
            total++; if (occupancy !== 3'd4) $display("FAIL full_occ[%0d]: got %0d expected 4", i, occupancy); else passed++;
            total++;
            if ({out_valid, out_data} !== {1'b1, exp_q[0]})
                $display("FAIL full_out[%0d]: got %b/%h expected 1/%h", i, out_valid, out_data, exp_q[0]);
            else passed++;
            void'(exp_q.pop_front());
            exp_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({out_valid, out_data} !== {1'b1, exp_q[0]})
                $display("FAIL full_drain[%0d]: got %b/%h expected 1/%h", i, out_valid, out_data, exp_q[0]);
            else passed++;
            void'(exp_q.pop_front());
            tick();
        end
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(32'h61 + i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        total++; if (occupancy !== 3'd3) $display("FAIL flush_occ_before: got %0d expected 3", occupancy); else passed++;
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready); else passed++;
        total++; if ({out_valid, out_data} !== 9'h000) $display("FAIL flush_out: got %b/%h expected 0/00", out_valid, out_data); else passed++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) $display("FAIL flush_occ_after: got %0d expected 0", occupancy); else passed++;
        total++; if ({out_valid, out_data} !== 9'h000) $display("FAIL flush_out_after: got %b/%h expected 0/00", out_valid, out_data); else passed++;
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL flush_leak: got %0d outputs expected 0", seen); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got[$];
        int         when[$];
        int         t0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(32'h71 + i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        total++; if (occupancy !== 3'd3) $display("FAIL rmid_occ_before: got %0d expected 3", occupancy); else passed++;
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b expected 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b expected 0", out_valid); else passed++;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) $display("FAIL rmid_occ_after: got %0d expected 0", occupancy); else passed++;
        total++; if ({out_valid, out_data} !== 9'h000) $display("FAIL rmid_out_after: got %b/%h expected 0/00", out_valid, out_data); else passed++;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        tick();
        t0 = cyc;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) begin
                got.push_back(out_data);
                when.push_back(cyc);
            end
        end
        total++; if (got.size() !== 1) $display("FAIL rmid_count: got %0d expected 1", got.size()); else passed++;
        total++; if (got[0] !== 8'h77) $display("FAIL rmid_data: got %h expected 77", got[0]); else passed++;
        total++; if (when[0] !== t0 + 3) $display("FAIL rmid_time: got %0d expected 3", when[0] - t0); else passed++;
    endtask

    // Model: queue of held entries, oldest first, each tagged with its stage.
    task automatic test_random();
        ent_t       q[$];
        ent_t       nq[$];
        ent_t       e;
        ent_t       ne;
        logic       exp_ov, exp_ir, free0;
        logic [7:0] exp_od;
        int         lim;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            reset     = ($urandom_range(0, 199) < 1);
            in_data   = 8'($urandom);
            #1;
            exp_ov = (q.size() > 0) && (q[0].pos == int'(DEPTH) - 1) && !flush && !reset;
            exp_od = exp_ov ? q[0].data : 8'h00;
            nq.delete();
            lim = int'(DEPTH) - 1;
            for (int j = 0; j < q.size(); j++) begin
                if (j == 0 && exp_ov && out_ready) continue;
                e = q[j];
                ne.data = e.data;
                ne.pos  = (e.pos + 1 < lim) ? e.pos + 1 : lim;
                nq.push_back(ne);
                lim = ne.pos - 1;
            end
            free0  = (nq.size() == 0) || (nq[nq.size()-1].pos > 0);
            exp_ir = free0 && !flush && !reset;
            total++; if (in_ready !== exp_ir) $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, exp_ir); else passed++;
            total++; if (out_valid !== exp_ov) $display("FAIL rand_out_valid[%0d]: got %b expected %b", n, out_valid, exp_ov); else passed++;
            total++; if (out_data !== exp_od) $display("FAIL rand_out_data[%0d]: got %h expected %h", n, out_data, exp_od); else passed++;
            total++; if (occupancy !== 3'(q.size())) $display("FAIL rand_occ[%0d]: got %0d expected %0d", n, occupancy, q.size()); else passed++;
            tick();
            if (reset || flush) begin
                q.delete();
            end else begin
                q = nq;
                if (in_valid && exp_ir) begin
                    ne.data = in_data;
                    ne.pos  = 0;
                    q.push_back(ne);
                end
            end
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_full_throughput();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
